// File: rtl/beam_capture_scheduler_if.sv
// beam_capture_scheduler_if
//   Bundles the three data paths of the capture scheduler:
//     - beamformer sample input (sample_valid / sample_data)
//     - result RAM port (ram_addr, ram_wdata, ram_wren, ram_rden, ram_q)
//     - UART byte stream (tx_data, tx_valid, tx_ready)
//   master : the scheduler side (drives RAM control and the tx stream)
//   slave  : the environment side (beamformer, RAM, UART)
interface beam_capture_scheduler_if #(
    parameter int unsigned DATA_W = 40,
    parameter int unsigned ADDR_W = 10
);
    logic              sample_valid;
    logic [DATA_W-1:0] sample_data;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_wren;
    logic              ram_rden;
    logic [DATA_W-1:0] ram_q;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        input  sample_valid, sample_data, ram_q, tx_ready,
        output ram_addr, ram_wdata, ram_wren, ram_rden, tx_data, tx_valid
    );

    modport slave (
        output sample_valid, sample_data, ram_q, tx_ready,
        input  ram_addr, ram_wdata, ram_wren, ram_rden, tx_data, tx_valid
    );
endinterface

// File: rtl/beam_capture_scheduler.sv
// beam_capture_scheduler
//   Sequences one beamformer acquisition: on arm, writes the burst of valid
//   samples into the result RAM, then streams the RAM out as a framed byte
//   stream: SYNC, count[15:8], count[7:0], each word LSB byte first, then an
//   XOR checksum over every byte after SYNC.
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   locked      : PLL lock; low aborts the frame back to IDLE
//   arm         : single-cycle start request (honoured only in IDLE)
//   bus         : sample input, RAM port and UART byte stream (master side)
//   busy        : high in every state except IDLE and DONE
//   done        : one-cycle pulse (DONE state) after the checksum byte transfers
//   overflow    : sticky, set when the capture fills the RAM; cleared on arm
//   word_count  : words captured in the current / last frame
module beam_capture_scheduler #(
    parameter int unsigned DATA_W    = 40,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned RD_LAT    = 2,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     locked,
    input  logic                     arm,
    beam_capture_scheduler_if.master bus,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    output logic [ADDR_W:0]          word_count
);

    localparam int unsigned   NBYTES = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT_SAMP,
        S_CAPTURE,
        S_RD_REQ,
        S_RD_WAIT,
        S_SEND_HDR,
        S_SEND_WORD,
        S_SEND_CSUM,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic              overflow_q, overflow_d;
    logic [ADDR_W:0]   rd_addr_q, rd_addr_d;
    logic [7:0]        byte_idx_q, byte_idx_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [7:0]        csum_q, csum_d;

    logic [ADDR_W-1:0] ram_addr_c;
    logic [DATA_W-1:0] ram_wdata_c;
    logic              ram_wren_c;
    logic              ram_rden_c;
    logic              tx_valid_c;
    logic [7:0]        tx_byte_c;
    logic [15:0]       count16;
    logic [ADDR_W:0]   wc_inc;

    assign count16 = 16'(word_count_q);
    assign wc_inc  = word_count_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        overflow_d   = overflow_q;
        rd_addr_d    = rd_addr_q;
        byte_idx_d   = byte_idx_q;
        wait_cnt_d   = wait_cnt_q;
        word_d       = word_q;
        csum_d       = csum_q;
        ram_addr_c   = '0;
        ram_wdata_c  = '0;
        ram_wren_c   = 1'b0;
        ram_rden_c   = 1'b0;
        tx_valid_c   = 1'b0;
        tx_byte_c    = '0;

        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d      = S_WAIT_SAMP;
                    word_count_d = '0;
                    overflow_d   = 1'b0;
                    rd_addr_d    = '0;
                    byte_idx_d   = '0;
                    csum_d       = '0;
                end
            end

            S_WAIT_SAMP, S_CAPTURE: begin
                if (bus.sample_valid) begin
                    ram_wren_c   = 1'b1;
                    ram_addr_c   = word_count_q[ADDR_W-1:0];
                    ram_wdata_c  = bus.sample_data;
                    word_count_d = wc_inc;
                    state_d      = S_CAPTURE;
                    // Leave on the write that fills the RAM so the address never wraps.
                    if (wc_inc == DEPTH) begin
                        overflow_d = 1'b1;
                        state_d    = S_SEND_HDR;
                    end
                end else if (state_q == S_CAPTURE) begin
                    state_d = S_SEND_HDR;
                end
            end

            S_SEND_HDR: begin
                tx_valid_c = 1'b1;
                case (byte_idx_q)
                    8'd0:    tx_byte_c = SYNC_BYTE;
                    8'd1:    tx_byte_c = count16[15:8];
                    default: tx_byte_c = count16[7:0];
                endcase
                if (bus.tx_ready) begin
                    if (byte_idx_q != 8'd0) begin
                        csum_d = csum_q ^ tx_byte_c;
                    end
                    if (byte_idx_q == 8'd2) begin
                        byte_idx_d = '0;
                        rd_addr_d  = '0;
                        state_d    = S_RD_REQ;
                    end else begin
                        byte_idx_d = byte_idx_q + 8'd1;
                    end
                end
            end

            S_RD_REQ: begin
                ram_rden_c = 1'b1;
                ram_addr_c = rd_addr_q[ADDR_W-1:0];
                wait_cnt_d = '0;
                state_d    = S_RD_WAIT;
            end

            S_RD_WAIT: begin
                ram_addr_c = rd_addr_q[ADDR_W-1:0];
                if (wait_cnt_q == 8'(RD_LAT - 1)) begin
                    word_d     = bus.ram_q;
                    byte_idx_d = '0;
                    state_d    = S_SEND_WORD;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end

            S_SEND_WORD: begin
                // The word register shifts down one byte per transfer, so the
                // current byte is always in the low lane.
                tx_valid_c = 1'b1;
                tx_byte_c  = word_q[7:0];
                if (bus.tx_ready) begin
                    csum_d = csum_q ^ tx_byte_c;
                    word_d = word_q >> 8;
                    if (byte_idx_q == 8'(NBYTES - 1)) begin
                        byte_idx_d = '0;
                        if (rd_addr_q + 1'b1 == word_count_q) begin
                            state_d = S_SEND_CSUM;
                        end else begin
                            rd_addr_d = rd_addr_q + 1'b1;
                            state_d   = S_RD_REQ;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + 8'd1;
                    end
                end
            end

            S_SEND_CSUM: begin
                tx_valid_c = 1'b1;
                tx_byte_c  = csum_q;
                if (bus.tx_ready) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Loss of lock abandons the frame: outputs drop this cycle, IDLE next.
        if (!locked) begin
            state_d      = S_IDLE;
            word_count_d = word_count_q;
            overflow_d   = overflow_q;
            ram_wren_c   = 1'b0;
            ram_rden_c   = 1'b0;
            tx_valid_c   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
            rd_addr_q    <= '0;
            byte_idx_q   <= '0;
            wait_cnt_q   <= '0;
            word_q       <= '0;
            csum_q       <= '0;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            overflow_q   <= overflow_d;
            rd_addr_q    <= rd_addr_d;
            byte_idx_q   <= byte_idx_d;
            wait_cnt_q   <= wait_cnt_d;
            word_q       <= word_d;
            csum_q       <= csum_d;
        end
    end

    assign bus.ram_addr  = ram_addr_c;
    assign bus.ram_wdata = ram_wdata_c;
    assign bus.ram_wren  = ram_wren_c;
    assign bus.ram_rden  = ram_rden_c;
    assign bus.tx_valid  = tx_valid_c;
    assign bus.tx_data   = tx_valid_c ? tx_byte_c : 8'h00;

    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign overflow   = overflow_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_beam_capture_scheduler.sv
// tb_beam_capture_scheduler
//   Random bursts of samples are captured and streamed; the received frame,
//   RAM writes and status outputs are compared to a frame built directly from
//   the burst (header, LSB-first words, XOR checksum).
module tb_beam_capture_scheduler;

    localparam int unsigned DATA_W = 40;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned RD_LAT = 2;
    localparam logic [7:0]  SYNC   = 8'hA5;
    localparam int          DEPTH  = 1 << ADDR_W;
    localparam int          NB     = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              locked = 1'b0;
    logic              arm = 1'b0;
    logic              busy, done, overflow;
    logic [ADDR_W:0]   word_count;

    int n_checks = 0;
    int n_errors = 0;

    beam_capture_scheduler_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    beam_capture_scheduler #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .RD_LAT   (RD_LAT),
        .SYNC_BYTE(SYNC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .locked    (locked),
        .arm       (arm),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    // RAM model: read data appears RD_LAT cycles after a rden cycle;
    // without rden the read pipe fills with garbage.
    logic [DATA_W-1:0] mem  [DEPTH];
    logic [DATA_W-1:0] pipe [RD_LAT];

    always @(posedge clk) begin
        if (bus.ram_wren) mem[bus.ram_addr] <= bus.ram_wdata;
        pipe[0] <= bus.ram_rden ? mem[bus.ram_addr] : DATA_W'({$urandom(), $urandom()});
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.ram_q = pipe[RD_LAT-1];

    // tx_ready: always ready (mode 0) or randomly stalling (mode 1)
    int ready_mode = 0;
    initial begin
        bus.tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.tx_ready = (ready_mode == 0) ? 1'b1 : 1'(($urandom % 3) != 0);
        end
    end

    // Monitor
    logic [7:0]        byte_q [$];
    logic [ADDR_W-1:0] wr_addr_q [$];
    logic [DATA_W-1:0] wr_data_q [$];
    int                done_cnt = 0;
    int                stall_err = 0;
    logic              prev_stall = 1'b0;
    logic [7:0]        prev_data = '0;

    always @(negedge clk) begin
        if (rst_n && locked && prev_stall && (!bus.tx_valid || bus.tx_data != prev_data))
            stall_err++;
        prev_stall = bus.tx_valid && !bus.tx_ready;
        prev_data  = bus.tx_data;
        if (bus.tx_valid && bus.tx_ready) byte_q.push_back(bus.tx_data);
        if (bus.ram_wren) begin
            wr_addr_q.push_back(bus.ram_addr);
            wr_data_q.push_back(bus.ram_wdata);
        end
        if (done) done_cnt++;
    end

    logic [DATA_W-1:0] stim [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        byte_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cnt  = 0;
        stall_err = 0;
    endtask

    task automatic make_stim(input int len);
        stim.delete();
        for (int i = 0; i < len; i++) stim.push_back(DATA_W'({$urandom(), $urandom()}));
    endtask

    task automatic start_frame(input bit noise);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        repeat ($urandom % 3) tick();
        foreach (stim[i]) begin
            bus.sample_valid = 1'b1;
            bus.sample_data  = stim[i];
            arm = noise && (($urandom % 3) == 0);
            tick();
        end
        bus.sample_valid = 1'b0;
        bus.sample_data  = DATA_W'({$urandom(), $urandom()});
        arm = 1'b0;
    endtask

    task automatic finish_frame(input bit noise);
        int cyc = 0;
        while (done_cnt == 0 && cyc < 3000) begin
            arm = noise && (($urandom % 4) == 0);
            tick();
            cyc++;
        end
        arm = 1'b0;
        if (done_cnt == 0) check("done_timeout", 64'd0, 64'd1);
        repeat (5) tick();
    endtask

    // Reference: frame and write list follow directly from the burst.
    task automatic model_check(input string name);
        logic [7:0]        exp_b [$];
        logic [7:0]        cs;
        logic [15:0]       cnt;
        logic [DATA_W-1:0] w;
        int                n;
        int                m;
        n   = (stim.size() < DEPTH) ? stim.size() : DEPTH;
        cnt = 16'(n);
        exp_b.push_back(SYNC);
        exp_b.push_back(cnt[15:8]);
        exp_b.push_back(cnt[7:0]);
        cs = cnt[15:8] ^ cnt[7:0];
        for (int i = 0; i < n; i++) begin
            w = stim[i];
            for (int b = 0; b < NB; b++) begin
                exp_b.push_back(w[8*b +: 8]);
                cs = cs ^ w[8*b +: 8];
            end
        end
        exp_b.push_back(cs);

        check({name, "_nbytes"}, 64'(byte_q.size()), 64'(exp_b.size()));
        m = (byte_q.size() < exp_b.size()) ? byte_q.size() : exp_b.size();
        for (int i = 0; i < m; i++) check({name, "_byte"}, 64'(byte_q[i]), 64'(exp_b[i]));
        check({name, "_nwrites"}, 64'(wr_addr_q.size()), 64'(n));
        m = (wr_addr_q.size() < n) ? wr_addr_q.size() : n;
        for (int i = 0; i < m; i++) begin
            check({name, "_wr_addr"}, 64'(wr_addr_q[i]), 64'(i));
            check({name, "_wr_data"}, 64'(wr_data_q[i]), 64'(stim[i]));
        end
        check({name, "_word_count"}, 64'(word_count), 64'(n));
        check({name, "_overflow"}, 64'(overflow), 64'(stim.size() >= DEPTH));
        check({name, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check({name, "_tx_stable"}, 64'(stall_err), 64'd0);
        check({name, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    task automatic run_frame(input string name, input bit noise);
        clear_mon();
        start_frame(noise);
        finish_frame(noise);
        model_check(name);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_done"}, 64'(done), 64'd0);
        check({name, "_overflow"}, 64'(overflow), 64'd0);
        check({name, "_word_count"}, 64'(word_count), 64'd0);
        check({name, "_tx_valid"}, 64'(bus.tx_valid), 64'd0);
        check({name, "_tx_data"}, 64'(bus.tx_data), 64'd0);
        check({name, "_ram_wren"}, 64'(bus.ram_wren), 64'd0);
        check({name, "_ram_rden"}, 64'(bus.ram_rden), 64'd0);
        check({name, "_ram_addr"}, 64'(bus.ram_addr), 64'd0);
    endtask

    initial begin
        int cyc;
        bus.sample_valid = 1'b0;
        bus.sample_data  = '0;
        rst_n  = 1'b0;
        locked = 1'b1;
        repeat (3) tick();
        check_outputs_zero("reset");
        rst_n = 1'b1;
        tick();
        check_outputs_zero("post_reset");

        // Known vector: checksum byte EC, 19 bytes
        stim.delete();
        stim.push_back(40'h0102030405);
        stim.push_back(40'h1111111111);
        stim.push_back(40'hFFFFFFFFFF);
        ready_mode = 0;
        run_frame("basic", 1'b0);
        if (byte_q.size() > 0) check("basic_csum_const", 64'(byte_q[byte_q.size()-1]), 64'hEC);

        // Same vector with stalls
        ready_mode = 1;
        run_frame("stall", 1'b0);

        // Overflow: 12 samples into an 8-word RAM
        ready_mode = 0;
        make_stim(12);
        run_frame("overflow", 1'b0);

        // Stray arms during capture and send
        ready_mode = 1;
        make_stim(4);
        run_frame("rearm_ignored", 1'b1);

        for (int k = 0; k < 20; k++) begin
            ready_mode = int'($urandom % 2);
            make_stim(1 + int'($urandom % 12));
            run_frame("random", 1'($urandom % 2));
        end

        // Lock loss in SEND_WORD
        ready_mode = 0;
        make_stim(3);
        clear_mon();
        start_frame(1'b0);
        cyc = 0;
        while (byte_q.size() < 6 && cyc < 500) begin
            tick();
            cyc++;
        end
        check("lock_reach_send_word", 64'(byte_q.size() >= 6), 64'd1);
        locked = 1'b0;
        #1;
        check("lock_tx_valid_now", 64'(bus.tx_valid), 64'd0);
        tick();
        check("lock_busy_next", 64'(busy), 64'd0);
        check("lock_tx_valid_next", 64'(bus.tx_valid), 64'd0);
        locked = 1'b1;
        repeat (10) tick();
        check("lock_no_done", 64'(done_cnt), 64'd0);
        make_stim(5);
        run_frame("after_lock", 1'b0);

        // Async reset mid-capture
        make_stim(6);
        clear_mon();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        bus.sample_valid = 1'b1;
        bus.sample_data  = stim[0];
        tick();
        bus.sample_data  = stim[1];
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        bus.sample_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        make_stim(7);
        ready_mode = 1;
        run_frame("after_reset", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
